// File: rtl/pwm_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_timebase_ctrl
//   Timebase and configuration sequencer for one PWM channel. Holds the
//   prescaled period counter and the active configuration (period,
//   functions, compare1, compare2) that the PWM generator consumes. New
//   configurations are captured into a shadow set while the channel runs.
//   The shadow set is copied to the active set in a single edge at the next
//   counter wrap, so a waveform never runs on a mix of old and new values.
//
// Ports
//   clk, rst_n      peripheral clock, synchronous active-low reset
//   enable          channel run request (level)
//   prescale        counter advances every prescale+1 clk cycles
//   upd_valid/ready config handshake; transfer = upd_valid && upd_ready
//   upd_*           offered period / functions / compare1 / compare2
//   pwm_en          enable to the PWM generator
//   period, functions, compare1, compare2   active configuration
//   count_val       period counter value
//   period_end      1-cycle pulse, counter wrapped to 0
//   upd_done        1-cycle pulse, new configuration became active
// ---------------------------------------------------------------------------
module pwm_timebase_ctrl #(
  parameter int CNT_W   = 16,
  parameter int FUNC_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [CNT_W-1:0]   upd_period,
  input  logic [FUNC_W-1:0]  upd_functions,
  input  logic [CNT_W-1:0]   upd_compare1,
  input  logic [CNT_W-1:0]   upd_compare2,
  output logic               pwm_en,
  output logic [CNT_W-1:0]   period,
  output logic [FUNC_W-1:0]  functions,
  output logic [CNT_W-1:0]   compare1,
  output logic [CNT_W-1:0]   compare2,
  output logic [CNT_W-1:0]   count_val,
  output logic               period_end,
  output logic               upd_done
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   sh_period;
  logic [FUNC_W-1:0]  sh_functions;
  logic [CNT_W-1:0]   sh_compare1;
  logic [CNT_W-1:0]   sh_compare2;

  logic tick;
  logic wrap;
  logic xfer;

  // A prescale value lowered below the running presc_cnt ticks on the next
  // cycle instead of rolling presc_cnt all the way around, so a new prescale
  // takes hold immediately.
  assign tick = (state != ST_OFF) && (presc_cnt >= prescale);
  // The wrap decision always uses the currently active period; a config
  // applied at this wrap only governs the following period.
  assign wrap = tick && (count_val >= period);
  assign xfer = upd_valid && upd_ready;

  // NOTE: every register here is assigned with <= so all updates in one edge
  // see the pre-edge values; that is what makes the shadow->active copy and
  // the counter wrap land atomically in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_OFF;
      presc_cnt    <= '0;
      count_val    <= '0;
      pwm_en       <= 1'b0;
      period_end   <= 1'b0;
      upd_done     <= 1'b0;
      upd_ready    <= 1'b1;  // OFF state always accepts a configuration
      period       <= '0;
      functions    <= '0;
      compare1     <= '0;
      compare2     <= '0;
      sh_period    <= '0;
      sh_functions <= '0;
      sh_compare1  <= '0;
      sh_compare2  <= '0;
    end else begin
      period_end <= 1'b0;
      upd_done   <= 1'b0;

      case (state)
        ST_OFF: begin
          presc_cnt <= '0;
          count_val <= '0;
          if (xfer) begin
            period    <= upd_period;
            functions <= upd_functions;
            compare1  <= upd_compare1;
            compare2  <= upd_compare2;
            upd_done  <= 1'b1;
          end
          if (enable) begin
            state  <= ST_RUN;
            pwm_en <= 1'b1;
          end
        end

        ST_RUN, ST_PEND: begin
          if (!enable) begin
            // Stopping never drops a configuration: a pending shadow, or one
            // handed over in this very cycle, becomes active on the way out.
            state     <= ST_OFF;
            pwm_en    <= 1'b0;
            count_val <= '0;
            presc_cnt <= '0;
            upd_ready <= 1'b1;
            if (state == ST_PEND) begin
              period    <= sh_period;
              functions <= sh_functions;
              compare1  <= sh_compare1;
              compare2  <= sh_compare2;
              upd_done  <= 1'b1;
            end else if (xfer) begin
              period    <= upd_period;
              functions <= upd_functions;
              compare1  <= upd_compare1;
              compare2  <= upd_compare2;
              upd_done  <= 1'b1;
            end
          end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
              count_val <= wrap ? '0 : count_val + 1'b1;
            end
            if (wrap) begin
              period_end <= 1'b1;
            end

            if (state == ST_PEND) begin
              if (wrap) begin
                period    <= sh_period;
                functions <= sh_functions;
                compare1  <= sh_compare1;
                compare2  <= sh_compare2;
                upd_done  <= 1'b1;
                upd_ready <= 1'b1;
                state     <= ST_RUN;
              end
            end else if (xfer) begin
              // Captured only; a wrap in this same cycle does not apply it.
              sh_period    <= upd_period;
              sh_functions <= upd_functions;
              sh_compare1  <= upd_compare1;
              sh_compare2  <= upd_compare2;
              upd_ready    <= 1'b0;
              state        <= ST_PEND;
            end
          end
        end

        default: begin
          state     <= ST_OFF;
          pwm_en    <= 1'b0;
          upd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_timebase_ctrl
//   Scenario-per-task bench. Each task pushes the cycle-by-cycle expected
//   output of its scenario into a queue and pops one entry per clock,
//   comparing it against the DUT outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_timebase_ctrl;

  localparam int CNT_W   = 16;
  localparam int FUNC_W  = 8;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic               upd_valid;
  logic               upd_ready;
  logic [CNT_W-1:0]   upd_period;
  logic [FUNC_W-1:0]  upd_functions;
  logic [CNT_W-1:0]   upd_compare1;
  logic [CNT_W-1:0]   upd_compare2;
  logic               pwm_en;
  logic [CNT_W-1:0]   period;
  logic [FUNC_W-1:0]  functions;
  logic [CNT_W-1:0]   compare1;
  logic [CNT_W-1:0]   compare2;
  logic [CNT_W-1:0]   count_val;
  logic               period_end;
  logic               upd_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic             en;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] c1;
    logic             pe;
    logic             ud;
    logic             rdy;
  } exp_t;

  exp_t sb_q[$];

  pwm_timebase_ctrl #(
    .CNT_W  (CNT_W),
    .FUNC_W (FUNC_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .prescale     (prescale),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_period   (upd_period),
    .upd_functions(upd_functions),
    .upd_compare1 (upd_compare1),
    .upd_compare2 (upd_compare2),
    .pwm_en       (pwm_en),
    .period       (period),
    .functions    (functions),
    .compare1     (compare1),
    .compare2     (compare2),
    .count_val    (count_val),
    .period_end   (period_end),
    .upd_done     (upd_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic en, input int cnt, input int per,
                              input int c1, input logic pe, input logic ud,
                              input logic rdy);
    exp_t e;
    e.en  = en;
    e.cnt = CNT_W'(cnt);
    e.per = CNT_W'(per);
    e.c1  = CNT_W'(c1);
    e.pe  = pe;
    e.ud  = ud;
    e.rdy = rdy;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.en  = pwm_en;
    o.cnt = count_val;
    o.per = period;
    o.c1  = compare1;
    o.pe  = period_end;
    o.ud  = upd_done;
    o.rdy = upd_ready;
    return o;
  endfunction

  // Stimulus only: hold reset over two edges with all inputs idle.
  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    prescale      = '0;
    upd_valid     = 1'b0;
    upd_period    = '0;
    upd_functions = '0;
    upd_compare1  = '0;
    upd_compare2  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus only: offer a configuration and request run at this negedge.
  task automatic start_run(input int per, input int c1, input int presc);
    enable        = 1'b1;
    prescale      = PRESC_W'(presc);
    upd_valid     = 1'b1;
    upd_period    = CNT_W'(per);
    upd_functions = 8'hA5;
    upd_compare1  = CNT_W'(c1);
    upd_compare2  = 16'h0003;
  endtask

  task automatic test_reset();
    exp_t e, o;
    do_reset();
    e = mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    o = observe();
    checks++;
    if (o !== e || functions !== '0 || compare2 !== '0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h functions=%h compare2=%h", o, e,
               functions, compare2);
    end
  endtask

  // prescale=0, period=4: count 0..4 repeating, wrap every 5 clk.
  task automatic test_basic_count();
    exp_t e, o;
    do_reset();
    start_run(4, 1, 0);
    sb_q.push_back(mk(1'b1, 0, 4, 1, 1'b0, 1'b1, 1'b1));
    for (int j = 2; j <= 12; j++)
      sb_q.push_back(mk(1'b1, (j - 1) % 5, 4, 1, ((j - 1) % 5) == 0, 1'b0, 1'b1));
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_count cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 1) begin
        checks++;
        if (functions !== 8'hA5 || compare2 !== 16'h0003) begin
          failures++;
          $display("FAIL basic_load functions=%h compare2=%h exp a5/0003",
                   functions, compare2);
        end
        upd_valid = 1'b0;
      end
    end
  endtask

  // prescale=2, period=3: count steps every 3 clk, wraps every 12 clk.
  task automatic test_prescale();
    exp_t e, o;
    do_reset();
    start_run(3, 0, 2);
    for (int j = 1; j <= 26; j++)
      sb_q.push_back(mk(1'b1, ((j - 1) / 3) % 4, 3, 0,
                        (j > 1) && (((j - 1) % 12) == 0), j == 1, 1'b1));
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL prescale cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 1) upd_valid = 1'b0;
    end
  endtask

  // period=9 running; new period=4/cmp1=2 offered at count 3 waits for wrap.
  task automatic test_shadow_update();
    exp_t e, o;
    int   cnt, per, c1;
    do_reset();
    start_run(9, 7, 0);
    for (int j = 1; j <= 17; j++) begin
      cnt = (j <= 10) ? j - 1 : (j - 11) % 5;
      per = (j <= 10) ? 9 : 4;
      c1  = (j <= 10) ? 7 : 2;
      sb_q.push_back(mk(1'b1, cnt, per, c1, (j == 11) || (j == 16),
                        (j == 1) || (j == 11), !(j >= 5 && j <= 10)));
    end
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL shadow_update cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 1) upd_valid = 1'b0;
      if (j == 4) begin
        upd_valid    = 1'b1;
        upd_period   = 16'd4;
        upd_compare1 = 16'd2;
      end
      if (j == 5) upd_valid = 1'b0;
    end
  endtask

  // Transfer in the cycle count_val==period: applied one full period later.
  task automatic test_wrap_collision();
    exp_t e, o;
    int   cnt, per;
    do_reset();
    start_run(5, 1, 0);
    for (int j = 1; j <= 16; j++) begin
      cnt = (j <= 12) ? (j - 1) % 6 : (j - 13) % 3;
      per = (j <= 12) ? 5 : 2;
      sb_q.push_back(mk(1'b1, cnt, per, (j <= 12) ? 1 : 0,
                        (j == 7) || (j == 13) || (j == 16),
                        (j == 1) || (j == 13), !(j >= 7 && j <= 12)));
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_collision cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 1) upd_valid = 1'b0;
      if (j == 6) begin
        upd_valid    = 1'b1;
        upd_period   = 16'd2;
        upd_compare1 = 16'd0;
      end
      if (j == 7) upd_valid = 1'b0;
    end
  endtask

  // Disable while PEND: shadow becomes active on the way to OFF.
  task automatic test_pend_disable();
    exp_t e, o;
    do_reset();
    start_run(9, 7, 0);
    sb_q.push_back(mk(1'b1, 0, 9, 7, 1'b0, 1'b1, 1'b1));
    sb_q.push_back(mk(1'b1, 1, 9, 7, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b1, 2, 9, 7, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b1, 3, 9, 7, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(1'b0, 0, 6, 3, 1'b0, 1'b1, 1'b1));
    sb_q.push_back(mk(1'b0, 0, 6, 3, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b0, 0, 6, 3, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL pend_disable cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 1) upd_valid = 1'b0;
      if (j == 3) begin
        upd_valid    = 1'b1;
        upd_period   = 16'd6;
        upd_compare1 = 16'd3;
      end
      if (j == 4) begin
        upd_valid = 1'b0;
        enable    = 1'b0;
      end
    end
  endtask

  // Reset while PEND drops the shadow; then run with period=0 (wrap each tick).
  task automatic test_reset_in_pend();
    exp_t e, o;
    do_reset();
    start_run(9, 7, 0);
    sb_q.push_back(mk(1'b1, 0, 9, 7, 1'b0, 1'b1, 1'b1));
    sb_q.push_back(mk(1'b1, 1, 9, 7, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b1, 2, 9, 7, 1'b0, 1'b0, 1'b0));
    for (int j = 4; j <= 8; j++)
      sb_q.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1));
    for (int j = 10; j <= 13; j++)
      sb_q.push_back(mk(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b1));
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_in_pend cyc=%0d got=%h exp=%h", j, o, e);
      end
      if (j == 4) begin
        checks++;
        if (functions !== '0 || compare2 !== '0) begin
          failures++;
          $display("FAIL reset_in_pend_cfg functions=%h compare2=%h exp 0/0",
                   functions, compare2);
        end
      end
      if (j == 1) upd_valid = 1'b0;
      if (j == 2) begin
        upd_valid  = 1'b1;
        upd_period = 16'd3;
      end
      if (j == 3) begin
        upd_valid = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b0;
      end
      if (j == 4) rst_n = 1'b1;
      if (j == 8) enable = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_prescale();
    test_shadow_update();
    test_wrap_collision();
    test_pend_disable();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
